// File: rtl/maze_update_scheduler.sv
// Buffers maze-tile updates and commits them to the maze RAM only during
// vertical blanking, so a frame never shows a half-updated grid.
module maze_update_scheduler #(
   parameter int DEPTH      = 8,
   parameter int COLS       = 5,
   parameter int ROWS       = 4,
   parameter int Y_ACTIVE   = 480,
   parameter int MAX_COMMIT = 8
) (
   input  logic                         CLOCK,
   input  logic                         RESET,
   input  logic                         UPD_VALID,
   output logic                         UPD_READY,
   input  logic [2:0]                   UPD_X,
   input  logic [2:0]                   UPD_Y,
   input  logic [1:0]                   UPD_STATE,
   input  logic [9:0]                   PIXEL_Y,
   output logic                         WR_EN,
   output logic [4:0]                   WR_ADDR,
   output logic [1:0]                   WR_DATA,
   output logic                         DROPPED,
   output logic                         FRAME_DONE,
   output logic [$clog2(DEPTH+1)-1:0]   PENDING
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int KW = $clog2(MAX_COMMIT + 1);

   typedef enum logic [1:0] {
      S_ACTIVE,
      S_COMMIT,
      S_HOLD
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [6:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [KW-1:0] commits;
   logic          blank;
   logic          in_range;
   logic          push;
   logic          enq;
   logic          pop;
   logic          frame_end;
   logic [4:0]    addr;

   assign blank     = int'(PIXEL_Y) >= Y_ACTIVE;
   assign UPD_READY = int'(count) < DEPTH;
   assign in_range  = (int'(UPD_X) < COLS) && (int'(UPD_Y) < ROWS);
   assign push      = UPD_VALID && UPD_READY;
   assign enq       = push && in_range;
   assign addr      = 5'(int'(UPD_Y) * COLS + int'(UPD_X));
   assign PENDING   = count;

   always_comb begin
      state_nx  = state;
      pop       = 1'b0;
      frame_end = 1'b0;
      unique case (state)
         S_ACTIVE: begin
            if (blank) state_nx = S_COMMIT;
         end
         S_COMMIT: begin
            if (!blank) begin
               state_nx  = S_ACTIVE;
               frame_end = 1'b1;
            end else if (int'(commits) >= MAX_COMMIT) begin
               state_nx = S_HOLD;
            end else if (count != '0) begin
               pop = 1'b1;
            end
         end
         S_HOLD: begin
            if (!blank) begin
               state_nx  = S_ACTIVE;
               frame_end = 1'b1;
            end
         end
         default: state_nx = S_ACTIVE;
      endcase
   end

   // Storage has no reset; only the pointers and count define contents.
   always_ff @(posedge CLOCK) begin
      if (enq) mem[wr_ptr] <= {addr, UPD_STATE};
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state      <= S_ACTIVE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         commits    <= '0;
         WR_EN      <= 1'b0;
         WR_ADDR    <= '0;
         WR_DATA    <= '0;
         DROPPED    <= 1'b0;
         FRAME_DONE <= 1'b0;
      end else begin
         state      <= state_nx;
         WR_EN      <= pop;
         DROPPED    <= push && !in_range;
         FRAME_DONE <= frame_end;
         if (enq) wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr             <= rd_ptr + PW'(1);
            {WR_ADDR, WR_DATA} <= mem[rd_ptr];
         end
         if (enq && !pop) count <= count + CW'(1);
         else if (pop && !enq) count <= count - CW'(1);
         if (state == S_ACTIVE) commits <= '0;
         else if (pop) commits <= commits + KW'(1);
      end
   end

endmodule

// File: tb/tb_maze_update_scheduler.sv
// Scoreboard bench: two schedulers (MAX_COMMIT 8 and 2) share one stimulus
// stream; monitors pop expected writes in order.
module tb_maze_update_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       uv  = 1'b0;
   logic [2:0] ux  = '0;
   logic [2:0] uy  = '0;
   logic [1:0] us  = '0;
   logic [9:0] px  = 10'd100;

   logic       rdy0, wr0, drop0, fdn0;
   logic [4:0] wa0;
   logic [1:0] wd0;
   logic [3:0] pend0;
   logic       rdy1, wr1, drop1, fdn1;
   logic [4:0] wa1;
   logic [1:0] wd1;
   logic [3:0] pend1;

   int checks   = 0;
   int failures = 0;
   int w0 = 0, w1 = 0, d0 = 0, d1 = 0, f0 = 0, f1 = 0, ef = 0;
   logic [6:0] q0[$];
   logic [6:0] q1[$];

   always #20 clk = ~clk;

   maze_update_scheduler u0 (
      .CLOCK(clk), .RESET(rst), .UPD_VALID(uv), .UPD_READY(rdy0),
      .UPD_X(ux), .UPD_Y(uy), .UPD_STATE(us), .PIXEL_Y(px),
      .WR_EN(wr0), .WR_ADDR(wa0), .WR_DATA(wd0), .DROPPED(drop0),
      .FRAME_DONE(fdn0), .PENDING(pend0)
   );

   maze_update_scheduler #(.MAX_COMMIT(2)) u1 (
      .CLOCK(clk), .RESET(rst), .UPD_VALID(uv), .UPD_READY(rdy1),
      .UPD_X(ux), .UPD_Y(uy), .UPD_STATE(us), .PIXEL_Y(px),
      .WR_EN(wr1), .WR_ADDR(wa1), .WR_DATA(wd1), .DROPPED(drop1),
      .FRAME_DONE(fdn1), .PENDING(pend1)
   );

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      logic [6:0] e;
      if (wr0) begin
         w0++;
         if (q0.size() == 0) chk("u0_unexpected_wr", {wa0, wd0}, -1);
         else begin
            e = q0.pop_front();
            chk("u0_wr", {25'd0, wa0, wd0}, {25'd0, e});
         end
      end
      if (wr1) begin
         w1++;
         if (q1.size() == 0) chk("u1_unexpected_wr", {wa1, wd1}, -1);
         else begin
            e = q1.pop_front();
            chk("u1_wr", {25'd0, wa1, wd1}, {25'd0, e});
         end
      end
      if (drop0) d0++;
      if (drop1) d1++;
      if (fdn0) f0++;
      if (fdn1) f1++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      @(negedge clk);
      #1;
   endtask

   // a < 0 marks an update that must never be written
   task automatic push(input logic [2:0] xi, input logic [2:0] yi,
                       input logic [1:0] si, input int a);
      logic [4:0] a5;
      uv = 1'b1; ux = xi; uy = yi; us = si;
      tick;
      uv = 1'b0;
      if (a >= 0) begin
         a5 = 5'(a);
         q0.push_back({a5, si});
         q1.push_back({a5, si});
      end
   endtask

   task automatic blank_frame(input int n);
      px = 10'd480;
      repeat (n) tick;
      px = 10'd0;
      repeat (3) tick;
      ef++;
      settle;
   endtask

   initial begin
      repeat (2) tick;
      rst = 1'b0;
      settle;
      chk("rst_ready", int'(rdy0), 1);
      chk("rst_pending", int'(pend0), 0);
      chk("rst_wr_en", int'(wr0), 0);
      chk("rst_dropped", int'(drop0), 0);
      chk("rst_frame_done", int'(fdn0), 0);

      push(3'd2, 3'd1, 2'b11, 7);
      repeat (4) tick;
      settle;
      chk("t1_pending", int'(pend0), 1);
      chk("t1_no_wr_active", w0, 0);

      blank_frame(5);
      chk("t2_writes", w0, 1);
      chk("t2_pending", int'(pend0), 0);
      chk("t2_frame_done", f0, ef);

      push(3'd0, 3'd0, 2'd1, 0);
      push(3'd4, 3'd0, 2'd2, 4);
      push(3'd0, 3'd3, 2'd3, 15);
      push(3'd4, 3'd3, 2'd1, 19);
      push(3'd3, 3'd2, 2'd2, 13);
      push(3'd1, 3'd3, 2'd0, 16);
      push(3'd2, 3'd2, 2'd1, 12);
      push(3'd3, 3'd0, 2'd3, 3);
      settle;
      chk("t3_full_pending", int'(pend0), 8);
      chk("t3_full_ready", int'(rdy0), 0);
      uv = 1'b1; ux = 3'd1; uy = 3'd1; us = 2'd1;
      repeat (2) tick;
      uv = 1'b0;
      settle;
      chk("t3_9th_rejected", int'(pend0), 8);
      chk("t3_9th_no_drop", d0, 0);
      px = 10'd480;
      tick;
      settle;
      chk("t3_no_wr_first_blank_cycle", w0, 1);
      repeat (7) tick;
      settle;
      chk("t3_seven_consecutive", w0, 8);
      tick;
      settle;
      chk("t3_eight_consecutive", w0, 9);
      repeat (3) tick;
      px = 10'd0;
      repeat (3) tick;
      ef++;
      settle;
      chk("t3_pending_empty", int'(pend0), 0);
      chk("t4_u1_first_blank", w1, 3);
      chk("t4_u1_pending6", int'(pend1), 6);

      blank_frame(12);
      chk("t4_u1_hold_blank", w1, 5);
      chk("t4_u1_pending4", int'(pend1), 4);
      push(3'd1, 3'd1, 2'd2, 6);
      blank_frame(12);
      chk("t4_u0_single", w0, 10);
      chk("t4_u1_blank_a", w1, 7);
      chk("t4_u1_pending3", int'(pend1), 3);
      blank_frame(12);
      chk("t4_u1_blank_b", w1, 9);
      chk("t4_u1_pending1", int'(pend1), 1);
      blank_frame(12);
      chk("t4_u1_blank_c", w1, 10);
      chk("t4_u1_pending0", int'(pend1), 0);

      push(3'd5, 3'd0, 2'd1, -1);
      tick;
      push(3'd0, 3'd4, 2'd1, -1);
      tick;
      settle;
      chk("t5_dropped", d0, 2);
      chk("t5_dropped_u1", d1, 2);
      chk("t5_pending", int'(pend0), 0);
      blank_frame(6);
      chk("t5_no_wr", w0, 10);

      push(3'd1, 3'd0, 2'd1, 1);
      push(3'd2, 3'd0, 2'd2, -1);
      push(3'd3, 3'd0, 2'd3, -1);
      settle;
      chk("t6_pending3", int'(pend0), 3);
      px = 10'd500;
      repeat (2) tick;
      settle;
      chk("t6_one_commit", w0, 11);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      settle;
      chk("t6_wr_en_low", int'(wr0), 0);
      chk("t6_pending_cleared", int'(pend0), 0);
      chk("t6_u1_pending_cleared", int'(pend1), 0);
      repeat (5) tick;
      settle;
      chk("t6_no_more_wr", w0, 11);
      chk("t6_u1_no_more_wr", w1, 11);
      px = 10'd0;
      repeat (3) tick;
      ef++;
      settle;

      push(3'd1, 3'd2, 2'd2, 11);
      blank_frame(4);
      chk("final_u0_writes", w0, 12);
      chk("final_u1_writes", w1, 12);
      chk("final_u0_queue", q0.size(), 0);
      chk("final_u1_queue", q1.size(), 0);
      chk("final_u0_frames", f0, ef);
      chk("final_u1_frames", f1, ef);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
